de2_115_qsys_key_pio: RTL and testbench

Avalon-MM slave input port for the DE2-115 push-buttons (KEY[3:0]) and similar mechanical inputs. It is the read-side counterpart of the LED output PIO. The block synchronizes and debounces each pin, exposes the clean level and per-bit edge-capture flags through a 4-word register map, and raises a maskable level interrupt to the Nios II. It sits on the Qsys system interconnect next to the LED/7-segment output PIOs.

---
 rtl/de2_115_qsys_key_pio.sv | 97 +++++++++
 tb/tb_de2_115_qsys_key_pio.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/de2_115_qsys_key_pio.sv
// Avalon-MM input PIO for push-buttons: 2-flop synchronizer, per-bit debounce,
// edge capture with write-one-to-clear, and a maskable level interrupt.
module de2_115_qsys_key_pio #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int EDGE_TYPE       = 1,
   parameter int IDLE_HIGH       = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [WIDTH-1:0] IDLE_LEVEL = (IDLE_HIGH != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_deb;
   logic [WIDTH-1:0] r_irqmask;
   logic [WIDTH-1:0] r_edgecap;
   logic [CNT_W-1:0] r_cnt [WIDTH];

   logic             w_wr;
   logic [WIDTH-1:0] w_change;
   logic [WIDTH-1:0] w_done;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_deb_next;
   logic [CNT_W-1:0] w_cnt_next [WIDTH];
   logic             w_unused;

   assign w_wr     = chipselect && !write_n;
   assign w_clr    = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : {WIDTH{1'b0}};
   assign w_unused = &{1'b0, writedata};

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         // A bit only counts while it disagrees with the accepted level; any
         // agreement (including a glitch back) restarts the stability window.
         assign w_change[gi]   = r_sync2[gi] != r_deb[gi];
         assign w_done[gi]     = w_change[gi] && (r_cnt[gi] == CNT_LAST);
         assign w_cnt_next[gi] = (!w_change[gi] || w_done[gi]) ? {CNT_W{1'b0}}
                                                               : r_cnt[gi] + CNT_W'(1);
         assign w_edge[gi]     = w_done[gi] && ((EDGE_TYPE == 0) ?  r_sync2[gi] :
                                                (EDGE_TYPE == 1) ? !r_sync2[gi] : 1'b1);
      end
   endgenerate

   assign w_deb_next = (r_deb & ~w_done) | (r_sync2 & w_done);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1   <= IDLE_LEVEL;
         r_sync2   <= IDLE_LEVEL;
         r_deb     <= IDLE_LEVEL;
         r_irqmask <= {WIDTH{1'b0}};
         r_edgecap <= {WIDTH{1'b0}};
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= {CNT_W{1'b0}};
         end
      end else begin
         r_sync1 <= in_port;
         r_sync2 <= r_sync1;
         r_deb   <= w_deb_next;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= w_cnt_next[i];
         end
         if (w_wr && address == 2'd2) begin
            r_irqmask <= writedata[WIDTH-1:0];
         end
         // Set has priority over a simultaneous clear so no event is lost.
         r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      end
   end

   always_comb begin
      readdata = 32'd0;
      case (address)
         2'd0:    readdata[WIDTH-1:0] = r_deb;
         2'd1:    readdata[WIDTH-1:0] = r_sync2;
         2'd2:    readdata[WIDTH-1:0] = r_irqmask;
         default: readdata[WIDTH-1:0] = r_edgecap;
      endcase
   end

   assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_de2_115_qsys_key_pio.sv
// Self-checking bench for the key PIO: register reads, debounce timing,
// W1C/set collision, interrupt masking and reset during a debounce window.
module tb_de2_115_qsys_key_pio;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q [$];

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] exp;
   } rd_vec_t;

   typedef struct {
      logic [3:0] mask;
      logic       exp_irq;
   } mask_vec_t;

   rd_vec_t   rst_tbl  [4];
   mask_vec_t mask_tbl [7];

   de2_115_qsys_key_pio #(
      .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_HIGH(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] e, input string name);
      logic [31:0] exp_v;
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      exp_q.push_back(e);
      #1;
      exp_v = exp_q.pop_front();
      $display("rd %s addr=%0d data=%h", name, a, readdata);
      check(name, readdata, exp_v);
      chipselect = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      $display("wr addr=%0d data=%h", a, d);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_tbl[0] = '{2'd0, 32'hF};
      rst_tbl[1] = '{2'd1, 32'hF};
      rst_tbl[2] = '{2'd2, 32'h0};
      rst_tbl[3] = '{2'd3, 32'h0};
      mask_tbl[0] = '{4'h0, 1'b0};
      mask_tbl[1] = '{4'h4, 1'b1};
      mask_tbl[2] = '{4'h1, 1'b0};
      mask_tbl[3] = '{4'hB, 1'b0};
      mask_tbl[4] = '{4'hF, 1'b1};
      mask_tbl[5] = '{4'hC, 1'b1};
      mask_tbl[6] = '{4'h0, 1'b0};

      reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = 32'd0; in_port = 4'hF;
      tick(2);
      reset_n = 1'b1;

      // Reset state
      for (int i = 0; i < 4; i++) rd(rst_tbl[i].addr, rst_tbl[i].exp, "reset_read");
      check("reset_irq", {31'd0, irq}, 32'd0);

      // Clean press on bit 0: visible exactly 5 edges after sampling
      wr(2'd2, 32'h1);
      in_port = 4'hE;
      for (int i = 0; i <= 5; i++) begin
         tick(1);
         rd(2'd0, (i == 5) ? 32'hE : 32'hF, "press_data");
         rd(2'd3, (i == 5) ? 32'h1 : 32'h0, "press_edgecap");
         check("press_irq", {31'd0, irq}, (i == 5) ? 32'd1 : 32'd0);
      end
      in_port = 4'hF;
      tick(8);
      rd(2'd0, 32'hF, "release_data");
      rd(2'd3, 32'h1, "release_no_flag");
      wr(2'd3, 32'hF);
      check("w1c_irq_clear", {31'd0, irq}, 32'd0);

      // Bounce on bit 1, then hold low
      for (int s = 0; s < 10; s++) begin
         in_port[1] = (s % 2 == 0) ? 1'b0 : 1'b1;
         tick(2);
      end
      rd(2'd0, 32'hF, "bounce_data_hold");
      rd(2'd3, 32'h0, "bounce_no_flag");
      in_port[1] = 1'b0;
      for (int i = 0; i <= 5; i++) begin
         tick(1);
         rd(2'd0, (i == 5) ? 32'hD : 32'hF, "bounce_data");
         rd(2'd3, (i == 5) ? 32'h2 : 32'h0, "bounce_edgecap");
      end
      in_port = 4'hF;
      tick(8);
      rd(2'd0, 32'hF, "bounce_release_data");
      rd(2'd3, 32'h2, "bounce_release_flag");

      // W1C clears only selected bits
      in_port = 4'hE;
      tick(6);
      in_port = 4'hF;
      tick(8);
      rd(2'd3, 32'h3, "edgecap_two");
      wr(2'd3, 32'h1);
      rd(2'd3, 32'h2, "w1c_partial");

      // Clear of bit 1 on the same edge bit 1 gets a new event: set wins
      in_port = 4'hD;
      tick(5);
      wr(2'd3, 32'h2);
      rd(2'd3, 32'h2, "collision_set_wins");
      rd(2'd0, 32'hD, "collision_data");
      in_port = 4'hF;
      tick(8);
      wr(2'd3, 32'hF);
      rd(2'd3, 32'h0, "w1c_all");

      // Mask gating with edgecap = 0x4
      in_port = 4'hB;
      tick(6);
      in_port = 4'hF;
      tick(8);
      rd(2'd3, 32'h4, "mask_edgecap");
      for (int i = 0; i < 7; i++) begin
         wr(2'd2, {28'd0, mask_tbl[i].mask});
         rd(2'd2, {28'd0, mask_tbl[i].mask}, "irqmask_read");
         check("mask_irq", {31'd0, irq}, {31'd0, mask_tbl[i].exp_irq});
      end
      wr(2'd2, 32'h4);

      // Reset in the middle of a bit-2 debounce window
      in_port = 4'hB;
      tick(3);
      reset_n = 1'b0;
      #1;
      rd(2'd0, 32'hF, "midreset_data");
      rd(2'd1, 32'hF, "midreset_raw");
      rd(2'd3, 32'h0, "midreset_edgecap");
      check("midreset_irq", {31'd0, irq}, 32'd0);
      tick(1);
      reset_n = 1'b1;
      for (int i = 0; i <= 5; i++) begin
         tick(1);
         rd(2'd0, (i == 5) ? 32'hB : 32'hF, "postreset_data");
         rd(2'd3, (i == 5) ? 32'h4 : 32'h0, "postreset_edgecap");
      end
      rd(2'd2, 32'h0, "postreset_mask");
      check("postreset_irq", {31'd0, irq}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
